rtc_tick_ctrl: RTL and testbench
================================

Name: rtc_tick_ctrl

Overview:
- Turns the asynchronous real-time-clock input into single-cycle timer tick enables in the clk_i domain.
- Sequences the existing 2-flop `synch` synchronizer, detects rising edges and applies a programmable prescaler.
- Buffers ticks while the timer is stalled, for example during a software write to mtime.
- Sits between the RTC pad and the mtime counter inside the timer unit.

Parameters:
- SYNC_STAGES, 2, synchronizer depth passed to `synch`; must be at least 2.
- DIV_W, 16, width of the prescaler divider and counter.
- PEND_W, 4, width of the pending-tick counter; it saturates at 2^PEND_W-1.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  tick generation enable, level-sensitive.
- div_i  in  DIV_W  prescaler; one tick per (div_i+1) RTC rising edges.
- rtc_i  in  1  asynchronous RTC input; goes only to the synchronizer.
- stall_i  in  1  timer busy; ticks are queued instead of issued.
- ovf_clr_i  in  1  clears ovf_o.
- tick_o  out  1  registered single-cycle tick enable to mtime.
- pend_o  out  PEND_W  number of queued ticks.
- ovf_o  out  1  sticky flag: a tick was lost to saturation.
- active_o  out  1  high in the RUN state.

Behaviour:
- Reset: state IDLE; synchronizer flops 0; edge register rtc_q, prescaler cnt, arm counter, pend_o, tick_o, ovf_o and active_o all 0.
- Edge detect:
  - rtc_s is the `synch` output; rtc_q <= rtc_s every cycle, in every state.
  - rise = rtc_s & ~rtc_q.
  - Only rising edges count.
- FSM:
  - IDLE: cnt=0, pend=0, tick_o=0. en_i=1 -> ARM.
  - ARM: arm counter counts SYNC_STAGES cycles; rises are ignored; rtc_q keeps tracking so no false edge appears. Counter done -> RUN. en_i=0 -> IDLE.
  - RUN: active_o=1. en_i=0 -> IDLE next edge; cnt and pend are cleared and no further tick_o is issued.
- Prescaler (RUN only):
  - On rise: if cnt >= div_i, then cnt <= 0 and a tick event fires; else cnt <= cnt+1.
  - div_i=0 gives one event per rise.
  - div_i is sampled live. Lowering div_i below cnt fires on the next rise; it never wraps.
- Issue/queue, evaluated per cycle in RUN:
  - event, !stall_i, pend=0: tick_o=1 next cycle.
  - stall_i with event: pend+1. If pend is already at max, pend holds and ovf_o is set.
  - !stall_i, pend>0, no event: tick_o=1 and pend-1.
  - !stall_i, pend>0, event: tick_o=1 and pend unchanged (one in, one out).
  - stall_i, no event: tick_o=0 and pend holds.
  - At most one tick_o per cycle; tick_o is never asserted while the registered stall_i of that cycle is high.
- ovf_o: set has priority over ovf_clr_i in the same cycle. It is not cleared by en_i; only ovf_clr_i or reset clear it.
- Latency:
  - rtc_i first sampled high at edge k -> rtc_s high after edge k+SYNC_STAGES-1.
  - tick_o is high during the cycle after edge k+SYNC_STAGES (div_i=0, no stall).
- Reset mid-operation: returns immediately to the reset values above; the first rise after reset can only be seen after re-arming.
- Minimum RTC high and low times are 2 clk_i cycles. Faster input is out of spec; edges may be missed, with no error flag.

Decomposition:
- Package rtc_tick_pkg holds:
  - state_e typedef (IDLE, ARM, RUN), 2-bit encoding.
  - Constant for the pend_o saturation value as a function of PEND_W.
- One sub-module: the existing `synch` synchronizer, instantiated with STAGES=SYNC_STAGES. It is the only place rtc_i is consumed.
- Everything else stays flat in rtc_tick_ctrl.

Test Plan:
- Arm latency: reset, en_i=1 with rtc_i already high -> active_o=1 exactly SYNC_STAGES+1 cycles later, and no tick_o from the pre-existing high level.
- Basic tick: div_i=0, rtc_i square wave of period 10 clk_i, RUN -> one tick_o per period, asserted 3 cycles after rtc_i rises (SYNC_STAGES=2).
- Prescale: div_i=3, 12 RTC rises -> exactly 3 tick_o pulses, on rises 4, 8 and 12. Then set div_i=1 with cnt=2 -> tick on the next rise.
- Stall queue: div_i=0, stall_i high for 5 RTC rises -> pend_o=5, no tick_o. Release -> 5 consecutive tick_o cycles, pend_o counts 4..0.
- Saturation: PEND_W=4, stall over 17 rises -> pend_o=15 and ovf_o=1. Assert ovf_clr_i in the same cycle as another saturating event -> ovf_o stays 1; clear alone -> ovf_o=0.
- Disable/reset: en_i=0 with pend_o=3 -> next cycle pend_o=0, active_o=0, no tick_o. Async rst_ni pulse mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/rtc_tick_pkg.sv
// Shared types and constants for the RTC tick controller.
package rtc_tick_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Saturation value of a w-bit pending-tick counter.
   function automatic int unsigned pend_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/rtc_tick_ctrl_synch.sv
// Multi-flop synchronizer for a single asynchronous level.
module synch #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], din};
      end
   end

   assign dout = ff[STAGES-1];

endmodule

// File: rtl/rtc_tick_ctrl.sv
// RTC pad to mtime tick enables: sync, edge detect, prescale, stall queue.
module rtc_tick_ctrl
   import rtc_tick_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_W       = 16,
   parameter int PEND_W      = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic              rtc_i,
   input  logic              stall_i,
   input  logic              ovf_clr_i,
   output logic              tick_o,
   output logic [PEND_W-1:0] pend_o,
   output logic              ovf_o,
   output logic              active_o
);

   localparam int ARM_W = $clog2(SYNC_STAGES);
   localparam logic [ARM_W-1:0] ARM_LAST =
      ARM_W'(SYNC_STAGES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX =
      PEND_W'(pend_max(PEND_W));

   state_e state, state_n;

   logic              rtc_s;
   logic              rtc_q;
   logic              rise;
   logic              ev;
   logic              ovf_set;
   logic              tick_n;
   logic              ovf_n;
   logic [DIV_W-1:0]  cnt, cnt_n;
   logic [ARM_W-1:0]  arm_cnt, arm_n;
   logic [PEND_W-1:0] pend, pend_n;

   synch #(
      .STAGES (SYNC_STAGES)
   ) u_synch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .din    (rtc_i),
      .dout   (rtc_s)
   );

   assign rise   = rtc_s & ~rtc_q;
   assign pend_o = pend;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         rtc_q    <= 1'b0;
         cnt      <= '0;
         arm_cnt  <= '0;
         pend     <= '0;
         tick_o   <= 1'b0;
         ovf_o    <= 1'b0;
         active_o <= 1'b0;
      end else begin
         state    <= state_n;
         rtc_q    <= rtc_s;
         cnt      <= cnt_n;
         arm_cnt  <= arm_n;
         pend     <= pend_n;
         tick_o   <= tick_n;
         ovf_o    <= ovf_n;
         active_o <= (state_n == RUN);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      arm_n   = arm_cnt;
      pend_n  = pend;
      tick_n  = 1'b0;
      ev      = 1'b0;
      ovf_set = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n  = '0;
            pend_n = '0;
            arm_n  = '0;
            if (en_i) state_n = ARM;
         end
         ARM: begin
            // Synchronizer settles here; rtc_q keeps tracking meanwhile.
            cnt_n  = '0;
            pend_n = '0;
            if (!en_i) begin
               state_n = IDLE;
               arm_n   = '0;
            end else if (arm_cnt == ARM_LAST) begin
               state_n = RUN;
               arm_n   = '0;
            end else begin
               arm_n = arm_cnt + 1'b1;
            end
         end
         RUN: begin
            if (!en_i) begin
               state_n = IDLE;
               cnt_n   = '0;
               pend_n  = '0;
            end else begin
               // >= so a lowered divider fires instead of wrapping.
               if (rise) begin
                  if (cnt >= div_i) begin
                     cnt_n = '0;
                     ev    = 1'b1;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end
               if (stall_i) begin
                  if (ev) begin
                     if (pend == PEND_MAX) ovf_set = 1'b1;
                     else pend_n = pend + 1'b1;
                  end
               end else if (ev || (pend != '0)) begin
                  tick_n = 1'b1;
                  if (!ev) pend_n = pend - 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      ovf_n = ovf_set ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_o);
   end

endmodule

// File: tb/tb_rtc_tick_ctrl.sv
// Directed self-checking bench for rtc_tick_ctrl.
module tb_rtc_tick_ctrl;

   logic        clk_i;
   logic        rst_ni;
   logic        en_i;
   logic [15:0] div_i;
   logic        rtc_i;
   logic        stall_i;
   logic        ovf_clr_i;
   logic        tick_o;
   logic [3:0]  pend_o;
   logic        ovf_o;
   logic        active_o;

   int checks;
   int failures;
   int ticks;

   rtc_tick_ctrl #(
      .SYNC_STAGES (2),
      .DIV_W       (16),
      .PEND_W      (4)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .div_i     (div_i),
      .rtc_i     (rtc_i),
      .stall_i   (stall_i),
      .ovf_clr_i (ovf_clr_i),
      .tick_o    (tick_o),
      .pend_o    (pend_o),
      .ovf_o     (ovf_o),
      .active_o  (active_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
      if (tick_o === 1'b1) ticks++;
   endtask

   task automatic rtc_period(input int hi, input int lo,
                             output int nt, output int first);
      int t0;
      t0    = ticks;
      first = -1;
      rtc_i = 1'b1;
      for (int i = 1; i <= hi + lo; i++) begin
         if (i == hi + 1) rtc_i = 1'b0;
         step();
         if (tick_o === 1'b1 && first < 0) first = i;
      end
      nt = ticks - t0;
   endtask

   task automatic test_reset();
      rst_ni    = 1'b0;
      en_i      = 1'b0;
      div_i     = 16'd0;
      rtc_i     = 1'b1;
      stall_i   = 1'b0;
      ovf_clr_i = 1'b0;
      repeat (3) step();
      checks++;
      if ({tick_o, pend_o, ovf_o, active_o} !== 7'd0) begin
         failures++;
         $display("FAIL reset_outs: got t=%b p=%0d o=%b a=%b exp all 0",
                  tick_o, pend_o, ovf_o, active_o);
      end
      rst_ni = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_arm_latency();
      int t0;
      t0   = ticks;
      en_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (active_o !== (i == 3)) begin
            failures++;
            $display("FAIL arm_active_%0d: got %b exp %b",
                     i, active_o, (i == 3));
         end
      end
      repeat (4) step();
      checks++;
      if (ticks - t0 != 0) begin
         failures++;
         $display("FAIL arm_no_tick: got %0d ticks exp 0", ticks - t0);
      end
   endtask

   task automatic test_basic_tick();
      int nt, first, t0;
      div_i = 16'd0;
      t0    = ticks;
      rtc_i = 1'b0;
      repeat (5) step();
      checks++;
      if (ticks - t0 != 0) begin
         failures++;
         $display("FAIL basic_fall: got %0d ticks exp 0", ticks - t0);
      end
      for (int p = 0; p < 3; p++) begin
         rtc_period(5, 5, nt, first);
         checks++;
         if (nt != 1) begin
            failures++;
            $display("FAIL basic_count_%0d: got %0d exp 1", p, nt);
         end
         checks++;
         if (first != 3) begin
            failures++;
            $display("FAIL basic_lat_%0d: got %0d exp 3", p, first);
         end
      end
   endtask

   task automatic test_prescale();
      int nt, first;
      div_i = 16'd3;
      for (int r = 1; r <= 12; r++) begin
         rtc_period(5, 5, nt, first);
         checks++;
         if (nt != ((r % 4 == 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL prescale_rise_%0d: got %0d exp %0d",
                     r, nt, (r % 4 == 0) ? 1 : 0);
         end
      end
      for (int r = 13; r <= 14; r++) begin
         rtc_period(5, 5, nt, first);
         checks++;
         if (nt != 0) begin
            failures++;
            $display("FAIL prescale_pre_%0d: got %0d exp 0", r, nt);
         end
      end
      div_i = 16'd1;
      rtc_period(5, 5, nt, first);
      checks++;
      if (nt != 1) begin
         failures++;
         $display("FAIL prescale_lower: got %0d exp 1", nt);
      end
      div_i = 16'd0;
   endtask

   task automatic test_stall_queue();
      int nt, first, t0;
      t0      = ticks;
      stall_i = 1'b1;
      for (int p = 0; p < 5; p++) rtc_period(5, 5, nt, first);
      checks++;
      if (ticks - t0 != 0) begin
         failures++;
         $display("FAIL stall_no_tick: got %0d exp 0", ticks - t0);
      end
      checks++;
      if (pend_o !== 4'd5) begin
         failures++;
         $display("FAIL stall_pend: got %0d exp 5", pend_o);
      end
      stall_i = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         checks++;
         if (tick_o !== (i <= 5) ||
             pend_o !== ((i <= 5) ? 4'(5 - i) : 4'd0)) begin
            failures++;
            $display("FAIL drain_%0d: got t=%b p=%0d exp t=%b p=%0d",
                     i, tick_o, pend_o, (i <= 5),
                     (i <= 5) ? (5 - i) : 0);
         end
      end
   endtask

   task automatic test_saturation();
      int nt, first;
      stall_i = 1'b1;
      for (int p = 0; p < 17; p++) rtc_period(5, 5, nt, first);
      checks++;
      if (pend_o !== 4'd15 || ovf_o !== 1'b1) begin
         failures++;
         $display("FAIL sat: got p=%0d o=%b exp p=15 o=1", pend_o, ovf_o);
      end
      ovf_clr_i = 1'b1;
      step();
      ovf_clr_i = 1'b0;
      checks++;
      if (ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clr1: got %b exp 0", ovf_o);
      end
      rtc_i = 1'b1;
      step();
      step();
      ovf_clr_i = 1'b1;
      step();
      ovf_clr_i = 1'b0;
      checks++;
      if (ovf_o !== 1'b1 || pend_o !== 4'd15) begin
         failures++;
         $display("FAIL ovf_prio: got o=%b p=%0d exp o=1 p=15",
                  ovf_o, pend_o);
      end
      step();
      step();
      rtc_i = 1'b0;
      repeat (5) step();
      ovf_clr_i = 1'b1;
      step();
      ovf_clr_i = 1'b0;
      checks++;
      if (ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clr2: got %b exp 0", ovf_o);
      end
   endtask

   task automatic rearm_pend3();
      int nt, first;
      en_i    = 1'b1;
      stall_i = 1'b1;
      repeat (3) step();
      for (int p = 0; p < 3; p++) rtc_period(5, 5, nt, first);
   endtask

   task automatic test_disable_reset();
      int t0;
      en_i = 1'b0;
      step();
      rearm_pend3();
      checks++;
      if (pend_o !== 4'd3 || active_o !== 1'b1) begin
         failures++;
         $display("FAIL dis_setup: got p=%0d a=%b exp p=3 a=1",
                  pend_o, active_o);
      end
      t0      = ticks;
      stall_i = 1'b0;
      en_i    = 1'b0;
      step();
      checks++;
      if (pend_o !== 4'd0 || active_o !== 1'b0 || tick_o !== 1'b0) begin
         failures++;
         $display("FAIL dis: got p=%0d a=%b t=%b exp 0 0 0",
                  pend_o, active_o, tick_o);
      end
      repeat (4) step();
      checks++;
      if (ticks - t0 != 0) begin
         failures++;
         $display("FAIL dis_no_tick: got %0d exp 0", ticks - t0);
      end
      rearm_pend3();
      stall_i = 1'b0;
      step();
      checks++;
      if (tick_o !== 1'b1 || pend_o !== 4'd2) begin
         failures++;
         $display("FAIL mid_drain: got t=%b p=%0d exp t=1 p=2",
                  tick_o, pend_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({tick_o, pend_o, ovf_o, active_o} !== 7'd0) begin
         failures++;
         $display("FAIL async_rst: got t=%b p=%0d o=%b a=%b exp all 0",
                  tick_o, pend_o, ovf_o, active_o);
      end
      step();
      rst_ni = 1'b1;
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      ticks    = 0;
      test_reset();
      test_arm_latency();
      test_basic_tick();
      test_prescale();
      test_stall_queue();
      test_saturation();
      test_disable_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
